// File: rtl/turtle_cpu_data_bus.sv
// turtle_cpu_data_bus: address-decoded valid/ack interconnect from the core data port to NUM_CH channels,
// with per-access timeout, unmapped-address error and sticky first-error capture.
module turtle_cpu_data_bus #(
    parameter int                DATA_W         = 8,
    parameter int                D_ADDR_W       = 12,
    parameter int                NUM_CH         = 4,
    parameter int                SEL_W          = 2,
    parameter int                TIMEOUT_CYCLES = 15,
    parameter logic [DATA_W-1:0] ERR_RDATA      = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     core_req,
    input  logic                     core_we,
    input  logic [D_ADDR_W-1:0]      core_addr,
    input  logic [DATA_W-1:0]        core_wdata,
    output logic [DATA_W-1:0]        core_rdata,
    output logic                     core_stall,
    output logic [NUM_CH-1:0]        ch_req,
    output logic                     ch_we,
    output logic [D_ADDR_W-1:0]      ch_addr,
    output logic [DATA_W-1:0]        ch_wdata,
    input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
    input  logic [NUM_CH-1:0]        ch_ack,
    output logic                     bus_error,
    output logic [D_ADDR_W-1:0]      err_addr,
    input  logic                     err_clear
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SEL_W:0] NUM_CH_W = (SEL_W + 1)'(NUM_CH);

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   ch_req_q, ch_req_d;
    logic                ch_we_q, ch_we_d;
    logic [D_ADDR_W-1:0] ch_addr_q, ch_addr_d;
    logic [DATA_W-1:0]   ch_wdata_q, ch_wdata_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic                bus_error_q, bus_error_d;
    logic [D_ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [SEL_W-1:0]    sel;
    logic                unmapped, sel_ack, raise;
    logic [DATA_W-1:0]   sel_rdata;

    assign sel      = core_addr[D_ADDR_W-1 -: SEL_W];
    assign unmapped = {1'b0, sel} >= NUM_CH_W;

    always_comb begin
        sel_ack   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ack   = ch_ack[i];
                sel_rdata = ch_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ch_req_d     = ch_req_q;
        ch_we_d      = ch_we_q;
        ch_addr_d    = ch_addr_q;
        ch_wdata_d   = ch_wdata_q;
        sel_d        = sel_q;
        cnt_d        = cnt_q;
        core_rdata_d = core_rdata_q;
        raise        = 1'b0;
        case (state_q)
            IDLE: if (core_req) begin
                ch_we_d    = core_we;
                ch_addr_d  = core_addr;
                ch_wdata_d = core_wdata;
                sel_d      = sel;
                cnt_d      = '0;
                if (unmapped) begin
                    state_d      = DONE;
                    core_rdata_d = ERR_RDATA;
                    raise        = 1'b1;
                end else begin
                    state_d  = BUSY;
                    ch_req_d = NUM_CH'(1) << sel;
                end
            end
            BUSY: if (sel_ack) begin
                core_rdata_d = ch_we_q ? core_rdata_q : sel_rdata;
                ch_req_d     = '0;
                state_d      = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                ch_req_d     = '0;
                core_rdata_d = ERR_RDATA;
                raise        = 1'b1;
                state_d      = DONE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        // A new error beats a simultaneous clear and becomes the captured first error.
        bus_error_d = raise | (bus_error_q & ~err_clear);
        err_addr_d  = raise ? ((bus_error_q && !err_clear) ? err_addr_q : ch_addr_d)
                            : (err_clear ? '0 : err_addr_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ch_req_q     <= '0;
            ch_we_q      <= 1'b0;
            ch_addr_q    <= '0;
            ch_wdata_q   <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            core_rdata_q <= '0;
            bus_error_q  <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            ch_req_q     <= ch_req_d;
            ch_we_q      <= ch_we_d;
            ch_addr_q    <= ch_addr_d;
            ch_wdata_q   <= ch_wdata_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            core_rdata_q <= core_rdata_d;
            bus_error_q  <= bus_error_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign core_stall = core_req && (state_q != DONE);
    assign core_rdata = core_rdata_q;
    assign ch_req     = ch_req_q;
    assign ch_we      = ch_we_q;
    assign ch_addr    = ch_addr_q;
    assign ch_wdata   = ch_wdata_q;
    assign bus_error  = bus_error_q;
    assign err_addr   = err_addr_q;
endmodule

// File: tb/tb_turtle_cpu_data_bus.sv
// tb_turtle_cpu_data_bus: directed checks of turtle_cpu_data_bus with 4 channels and a 3-channel
// instance for the unmapped-address path.
module tb_turtle_cpu_data_bus;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0, core_we = 1'b0, err_clear = 1'b0;
    logic [11:0] core_addr = '0;
    logic [7:0]  core_wdata = '0;
    logic [7:0]  core_rdata;
    logic        core_stall, ch_we, bus_error;
    logic [3:0]  ch_req, ch_ack = '0;
    logic [11:0] ch_addr, err_addr;
    logic [7:0]  ch_wdata;
    logic [31:0] ch_rdata = '0;

    logic        r3_req = 1'b0, r3_clear = 1'b0;
    logic [11:0] r3_addr = '0;
    logic [7:0]  r3_rdata, r3_wdata;
    logic        r3_stall, r3_we, r3_err;
    logic [2:0]  r3_ch_req;
    logic [11:0] r3_ch_addr, r3_err_addr;

    int checks = 0, failures = 0, n;

    always #5 clk = ~clk;

    turtle_cpu_data_bus dut (
        .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall), .ch_req(ch_req),
        .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ack(ch_ack),
        .bus_error(bus_error), .err_addr(err_addr), .err_clear(err_clear)
    );

    turtle_cpu_data_bus #(.NUM_CH(3)) dut3 (
        .clk(clk), .reset(reset), .core_req(r3_req), .core_we(1'b0), .core_addr(r3_addr),
        .core_wdata(8'h00), .core_rdata(r3_rdata), .core_stall(r3_stall), .ch_req(r3_ch_req),
        .ch_we(r3_we), .ch_addr(r3_ch_addr), .ch_wdata(r3_wdata), .ch_rdata(24'h0), .ch_ack(3'b000),
        .bus_error(r3_err), .err_addr(r3_err_addr), .err_clear(r3_clear)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_ch_req", 32'(ch_req), 32'h0);
        check("rst_rdata", 32'(core_rdata), 32'h0);
        check("rst_err", 32'(bus_error), 32'h0);
        check("rst_stall", 32'(core_stall), 32'h0);
        tick();
        reset = 1'b0;

        // read 0x123 on ch0, acked in the first BUSY cycle
        core_req = 1'b1; core_addr = 12'h123;
        #1 check("rd_stall_idle", 32'(core_stall), 32'h1);
        tick();
        check("rd_ch_req", 32'(ch_req), 32'h1);
        check("rd_stall_busy", 32'(core_stall), 32'h1);
        ch_ack = 4'b0001; ch_rdata = 32'h0000_005A;
        tick();
        ch_ack = '0;
        check("rd_stall_done", 32'(core_stall), 32'h0);
        check("rd_rdata", 32'(core_rdata), 32'h5A);
        check("rd_ch_req_done", 32'(ch_req), 32'h0);
        core_req = 1'b0;
        tick();

        // write 0x8F0 <= 0xC3 on ch2, acked in the fifth BUSY cycle
        core_req = 1'b1; core_we = 1'b1; core_addr = 12'h8F0; core_wdata = 8'hC3;
        tick();
        core_wdata = 8'h00; core_addr = 12'h000;
        for (int i = 0; i < 5; i++) begin
            check("wr_ch_req", 32'(ch_req), 32'h4);
            check("wr_ch_we", 32'(ch_we), 32'h1);
            check("wr_ch_addr", 32'(ch_addr), 32'h8F0);
            check("wr_ch_wdata", 32'(ch_wdata), 32'hC3);
            if (i == 4) ch_ack = 4'b0100;
            tick();
        end
        ch_ack = '0;
        check("wr_done_stall", 32'(core_stall), 32'h0);
        check("wr_rdata_kept", 32'(core_rdata), 32'h5A);
        check("wr_no_err", 32'(bus_error), 32'h0);
        core_req = 1'b0; core_we = 1'b0;
        tick();

        // read 0x400 on ch1 with no ack: times out
        core_req = 1'b1; core_addr = 12'h400;
        tick();
        n = 0;
        while (ch_req[1] && n < 30) begin n++; tick(); end
        check("to_busy_cycles", 32'(n), 32'd15);
        check("to_stall", 32'(core_stall), 32'h0);
        check("to_rdata", 32'(core_rdata), 32'hFF);
        check("to_err", 32'(bus_error), 32'h1);
        check("to_err_addr", 32'(err_addr), 32'h400);
        core_req = 1'b0; err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("clr_err", 32'(bus_error), 32'h0);
        check("clr_err_addr", 32'(err_addr), 32'h0);

        // ch3 ack held throughout while ch1 is selected: ignored, timeout taken
        core_req = 1'b1; core_addr = 12'h5A0; ch_ack = 4'b1000; ch_rdata = 32'h1100_0000;
        tick();
        n = 0;
        while (ch_req[1] && n < 30) begin n++; tick(); end
        check("ign_busy_cycles", 32'(n), 32'd15);
        check("ign_rdata", 32'(core_rdata), 32'hFF);
        check("ign_err_addr", 32'(err_addr), 32'h5A0);
        core_req = 1'b0;
        tick();
        ch_ack = '0;

        // unmapped accesses on the 3-channel instance
        r3_req = 1'b1; r3_addr = 12'hC00;
        tick();
        check("um_stall", 32'(r3_stall), 32'h0);
        check("um_ch_req", 32'(r3_ch_req), 32'h0);
        check("um_rdata", 32'(r3_rdata), 32'hFF);
        check("um_err", 32'(r3_err), 32'h1);
        check("um_err_addr", 32'(r3_err_addr), 32'hC00);
        r3_req = 1'b0;
        tick();
        r3_req = 1'b1; r3_addr = 12'hC01;
        tick();
        check("um2_err_addr", 32'(r3_err_addr), 32'hC00);
        r3_req = 1'b0;
        tick();
        r3_req = 1'b1; r3_addr = 12'hC02; r3_clear = 1'b1;
        tick();
        r3_clear = 1'b0;
        check("um_clr_err", 32'(r3_err), 32'h1);
        check("um_clr_err_addr", 32'(r3_err_addr), 32'hC02);
        r3_req = 1'b0; r3_clear = 1'b1;
        tick();
        r3_clear = 1'b0;
        check("um_clr_only", 32'(r3_err), 32'h0);

        // asynchronous reset in the middle of a BUSY cycle
        core_req = 1'b1; core_addr = 12'h400;
        tick();
        check("ar_ch_req_pre", 32'(ch_req), 32'h2);
        #2 reset = 1'b1;
        #1;
        check("ar_ch_req", 32'(ch_req), 32'h0);
        check("ar_err", 32'(bus_error), 32'h0);
        check("ar_err_addr", 32'(err_addr), 32'h0);
        check("ar_ch_addr", 32'(ch_addr), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/turtle_cpu_data_bus.md
Name: turtle_cpu_data_bus

Overview:
Parametrised data-side interconnect between turtle_cpu_core and N memory-mapped channels. It generalises the fixed two-way internal/external select into address-decoded regions with a valid/ack handshake per channel. It stalls the core until the selected channel acknowledges. It also adds a timeout and an unmapped-address error path with sticky error capture. It sits between the core data port and the data memory / peripheral channels inside the subsystem.

Parameters:
DATA_W, 8, data bus width
D_ADDR_W, 12, data address width
NUM_CH, 4, number of target channels (1..2**SEL_W)
SEL_W, 2, number of top address bits used as channel index
TIMEOUT_CYCLES, 15, maximum BUSY cycles without ack before error (>=1)
ERR_RDATA, all ones ('1), read data returned on error

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
core_req  input  1  core data access valid this cycle
core_we  input  1  1 = write, 0 = read
core_addr  input  D_ADDR_W  access address
core_wdata  input  DATA_W  write data
core_rdata  output  DATA_W  read data, valid while state == DONE
core_stall  output  1  core must hold its access
ch_req  output  NUM_CH  one-hot request to the selected channel
ch_we  output  1  latched write enable
ch_addr  output  D_ADDR_W  latched address (full width, unmodified)
ch_wdata  output  DATA_W  latched write data
ch_rdata  input  NUM_CH*DATA_W  flattened per-channel read data, channel i at [i*DATA_W +: DATA_W]
ch_ack  input  NUM_CH  per-channel completion
bus_error  output  1  sticky error flag
err_addr  output  D_ADDR_W  address of the first error since clear
err_clear  input  1  clears bus_error and err_addr

Behaviour:
- Reset state (asynchronous, immediate on reset): state IDLE.
  - ch_req = 0, ch_we = 0, ch_addr = 0, ch_wdata = 0.
  - core_rdata = 0, bus_error = 0, err_addr = 0, timeout counter = 0.
- Decode: sel = core_addr[D_ADDR_W-1 -: SEL_W]. sel >= NUM_CH means unmapped.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if core_req, latch we/addr/wdata/sel into ch_* registers.
    - Mapped: go BUSY, ch_req[sel] <= 1, counter <= 0.
    - Unmapped: go DONE, core_rdata <= ERR_RDATA, raise the error.
  - BUSY: ch_req stays asserted and ch_* stay stable.
    - On ch_ack[sel]: core_rdata <= ch_rdata[sel] (reads; unchanged on writes), ch_req <= 0, go DONE.
    - Else, if counter == TIMEOUT_CYCLES-1: ch_req <= 0, core_rdata <= ERR_RDATA, raise the error, go DONE.
    - Else counter++.
  - DONE: unconditionally go IDLE next cycle.
- core_stall = core_req && (state != DONE). Combinational. Low whenever core_req is low.
- Minimum latency for an ack in the first BUSY cycle: the core is stalled 2 cycles and completes on the 3rd (DONE).
- Acks on non-selected channels, or in IDLE/DONE, are ignored.
- Ack wins over timeout when both occur in the same cycle.
- If core_req drops while BUSY, the transaction still completes or times out. There is no cancel, and the result is discarded in DONE.
- Writes are posted only on ack. A timed-out write is reported as an error, and no retry is made.
- Raising the error:
  - bus_error <= 1.
  - err_addr <= ch_addr if bus_error was 0; the first error is kept.
  - A raise in the same cycle as err_clear wins: bus_error = 1, err_addr = new address.
- err_clear alone: bus_error <= 0, err_addr <= 0.
- At most one outstanding transaction. No back-to-back without passing through DONE → IDLE.

Test Plan:
1. Reset asserted mid-BUSY (ch_req = 4'b0010) -> ch_req = 0 and state IDLE immediately, before the next clk edge. bus_error = 0.
2. Read addr 0x123 (ch 0), ch_ack[0] in first BUSY cycle with ch_rdata[0] = 0x5A -> core_stall high 2 cycles; core_rdata = 0x5A in DONE; ch_req = 4'b0001 for exactly 1 cycle.
3. Write addr 0x8F0 data 0xC3 (ch 2), ack after 5 cycles -> ch_we = 1, ch_addr = 0x8F0, ch_wdata = 0xC3 stable for 5 BUSY cycles; no error.
4. Read addr 0x400 (ch 1), no ack -> ch_req[1] drops after 15 BUSY cycles. core_rdata = 0xFF, bus_error = 1, err_addr = 0x400.
5. NUM_CH = 3, read addr 0xC00 -> DONE next cycle with no ch_req. core_rdata = 0xFF, bus_error = 1, err_addr = 0xC00. A second error at 0xC01 keeps err_addr = 0xC00.
6. Ack on ch 3 and timeout on ch 1 in the same cycle; separately, err_clear in the same cycle as a new error -> ack on ch 3 ignored, timeout taken. err_clear with a concurrent error leaves bus_error = 1.
